// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, sequencer state encoding and the operand-class helper
// for the ACC/BREG/ALU command sequencer.
package alu_seq_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int OP_W_DEF   = 3;

    typedef enum logic [OP_W_DEF-1:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        DEC = 3'd2,
        INC = 3'd3,
        OC  = 3'd4,
        BND = 3'd5,
        BOR = 3'd6,
        BXR = 3'd7
    } alu_opcode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5
    } seq_state_t;

    // Binary ops need BREG loaded with the operand before the ALU can run.
    function automatic logic is_binary(input logic [OP_W_DEF-1:0] op);
        return (op == ADD) || (op == SUB) || (op == BND) || (op == BOR) || (op == BXR);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command handshake plus datapath strobes between the sequencer (master) and the
// front end / register-ALU datapath (slave).
interface alu_op_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_ld;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_operand;
    logic [DATA_W-1:0] bus_data;
    logic              bus_oe;
    logic              breg_we;
    logic              acc_we;
    logic [OP_W-1:0]   alu_op;
    logic              alu_oe;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic [DATA_W-1:0] result;
    logic              busy;
    logic              done;
    logic              flag_z;
    logic              flag_c;

    modport master (
        input  cmd_valid, cmd_ld, cmd_op, cmd_operand, alu_result, alu_carry,
        output cmd_ready, bus_data, bus_oe, breg_we, acc_we, alu_op, alu_oe,
               result, busy, done, flag_z, flag_c
    );

    modport slave (
        output cmd_valid, cmd_ld, cmd_op, cmd_operand, alu_result, alu_carry,
        input  cmd_ready, bus_data, bus_oe, breg_we, acc_we, alu_op, alu_oe,
               result, busy, done, flag_z, flag_c
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Control FSM sequencing one ld/unary/binary command through ACC/BREG/ALU; done after 2/3/4 cycles.
// HLT freezes state and kills strobes; cmd_ready only in IDLE. Z/C flags exist only with ALU_SEQ_FLAGS_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               HLT,
    alu_op_sequencer_if.master io
);

    seq_state_t        state_q, state_d;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] operand_q;
    logic [DATA_W-1:0] result_q;
    logic              accept;
    logic              cmd_ready_s;
    logic              bus_oe_s, alu_oe_s, breg_we_s, acc_we_s, done_s;

    always_comb begin
        state_d     = state_q;
        cmd_ready_s = 1'b0;
        bus_oe_s    = 1'b0;
        alu_oe_s    = 1'b0;
        breg_we_s   = 1'b0;
        acc_we_s    = 1'b0;
        done_s      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready_s = ~HLT;
                if (io.cmd_valid && cmd_ready_s) begin
                    if (io.cmd_ld)
                        state_d = LOAD_A;
                    else if (is_binary(OP_W_DEF'(io.cmd_op)))
                        state_d = LOAD_B;
                    else
                        state_d = EXEC;
                end
            end
            LOAD_A: begin
                bus_oe_s = 1'b1;
                acc_we_s = 1'b1;
                state_d  = DONE;
            end
            LOAD_B: begin
                bus_oe_s  = 1'b1;
                breg_we_s = 1'b1;
                state_d   = EXEC;
            end
            EXEC: begin
                alu_oe_s = 1'b1;
                state_d  = WRITE;
            end
            WRITE: begin
                alu_oe_s = 1'b1;
                acc_we_s = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                done_s  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = io.cmd_valid & cmd_ready_s;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            op_q      <= '0;
            operand_q <= '0;
            result_q  <= '0;
        end else if (!HLT) begin
            state_q <= state_d;
            if (accept) begin
                op_q      <= io.cmd_op;
                operand_q <= io.cmd_operand;
            end
            if (state_q == LOAD_A)
                result_q <= operand_q;
            else if (state_q == WRITE)
                result_q <= io.alu_result;
        end
    end

    // Strobes are state decodes gated by HLT so a frozen cycle never writes anything.
    assign io.cmd_ready = cmd_ready_s;
    assign io.bus_oe    = bus_oe_s  & ~HLT;
    assign io.alu_oe    = alu_oe_s  & ~HLT;
    assign io.breg_we   = breg_we_s & ~HLT;
    assign io.acc_we    = acc_we_s  & ~HLT;
    assign io.done      = done_s    & ~HLT;
    assign io.bus_data  = (bus_oe_s & ~HLT) ? operand_q : '0;
    assign io.alu_op    = (state_q == EXEC || state_q == WRITE) ? op_q : '0;
    assign io.busy      = (state_q != IDLE);
    assign io.result    = result_q;

`ifdef ALU_SEQ_FLAGS_EN
    logic flag_z_q, flag_c_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else if (!HLT) begin
            if (state_q == LOAD_A) begin
                flag_z_q <= (operand_q == '0);
                flag_c_q <= 1'b0;
            end else if (state_q == WRITE) begin
                flag_z_q <= (io.alu_result == '0);
                flag_c_q <= io.alu_carry;
            end
        end
    end

    assign io.flag_z = flag_z_q;
    assign io.flag_c = flag_c_q;
`else
    logic unused_carry;
    assign unused_carry = io.alu_carry;
    assign io.flag_z    = 1'b0;
    assign io.flag_c    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ACC/BREG/ALU datapath around the DUT, directed
// scenarios followed by random commands (with random HLT windows) against an arithmetic model.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET;
    logic HLT;
    int   checks = 0;
    int   errors = 0;

    alu_op_sequencer_if #(.DATA_W(8), .OP_W(3)) u ();

    alu_op_sequencer dut (
        .CLK   (CLK),
        .RESET (RESET),
        .HLT   (HLT),
        .io    (u)
    );

    always #5 CLK = ~CLK;

    // Datapath the sequencer controls: ACC, BREG, shared bus and combinational ALU.
    logic [7:0] acc  = 8'h00;
    logic [7:0] breg = 8'h00;
    logic [7:0] bus;
    logic [8:0] alu_t;

    always_comb bus = u.bus_oe ? u.bus_data : (u.alu_oe ? u.alu_result : 8'h00);

    always @(posedge CLK) begin
        if (u.acc_we)  acc  <= bus;
        if (u.breg_we) breg <= bus;
    end

    always_comb begin
        alu_t = 9'h000;
        case (u.alu_op)
            3'd0: alu_t = {1'b0, acc} + {1'b0, breg};
            3'd1: alu_t = {1'b0, acc} - {1'b0, breg};
            3'd2: alu_t = {1'b0, acc} - 9'd1;
            3'd3: alu_t = {1'b0, acc} + 9'd1;
            3'd4: alu_t = {1'b0, ~acc};
            3'd5: alu_t = {1'b0, acc & breg};
            3'd6: alu_t = {1'b0, acc | breg};
            default: alu_t = {1'b0, acc ^ breg};
        endcase
        u.alu_result = alu_t[7:0];
        u.alu_carry  = alu_t[8];
    end

    // Reference model state
    int exp_acc = 0;
    int exp_res = 0;
    bit exp_z   = 1'b0;
    bit exp_c   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_bin(input int op);
        return (op == 0) || (op == 1) || (op == 5) || (op == 6) || (op == 7);
    endfunction

    // Value/carry an 8-bit ALU should produce, computed with plain integer arithmetic.
    task automatic ref_alu(input int op, input int a, input int b, output int r, output bit c);
        c = 1'b0;
        case (op)
            0: begin r = a + b; c = (r > 255); r = r % 256; end
            1: begin c = (a < b); r = (a - b + 256) % 256; end
            2: begin c = (a == 0); r = (a + 255) % 256; end
            3: begin c = (a == 255); r = (a + 1) % 256; end
            4: r = 255 - a;
            5: r = a & b;
            6: r = a | b;
            default: r = a ^ b;
        endcase
    endtask

    task automatic issue(input bit ld, input int op, input int opnd, input string tag);
        @(negedge CLK);
        #1;
        check({tag, " ready"}, {31'd0, u.cmd_ready}, 32'd1);
        check({tag, " idle done"}, {31'd0, u.done}, 32'd0);
        u.cmd_valid   = 1'b1;
        u.cmd_ld      = ld;
        u.cmd_op      = 3'(op);
        u.cmd_operand = 8'(opnd);
        @(negedge CLK);
        u.cmd_valid   = 1'b0;
        u.cmd_ld      = 1'($urandom);
        u.cmd_op      = 3'($urandom);
        u.cmd_operand = 8'($urandom);
    endtask

    // Follows a command from the cycle after its accept edge until done; halt_at counts
    // FSM visits (1 = first state after accept) and freezes there for halt_len cycles.
    task automatic watch(input bit ld, input int op, input int opnd,
                         input int halt_at, input int halt_len, input string tag);
        int cyc = 1, idx = 0;
        int n_acc = 0, n_breg = 0, n_alu = 0, n_bus = 0, p_acc = 0, p_breg = 0, p_alu = 0;
        int overlap = 0, bad_bus = 0;
        bit got = 1'b0, halted = 1'b0, bin, c;
        int lat, r;
        bin = !ld && is_bin(op);
        lat = ld ? 2 : (bin ? 4 : 3);
        while (cyc <= 24) begin
            #1;
            if (!halted && halt_len > 0 && idx + 1 == halt_at) begin
                HLT = 1'b1;
                #1;
                check({tag, " halt strobes"},
                      {27'd0, u.bus_oe, u.alu_oe, u.breg_we, u.acc_we, u.done}, 32'd0);
                check({tag, " halt ready"}, {31'd0, u.cmd_ready}, 32'd0);
                check({tag, " halt busy"}, {31'd0, u.busy}, 32'd1);
                repeat (halt_len) @(negedge CLK);
                cyc += halt_len;
                HLT = 1'b0;
                halted = 1'b1;
                #1;
            end
            idx++;
            if (u.acc_we)  begin n_acc++;  if (p_acc == 0)  p_acc = idx;  end
            if (u.breg_we) begin n_breg++; if (p_breg == 0) p_breg = idx; end
            if (u.alu_oe)  begin n_alu++;  if (p_alu == 0)  p_alu = idx;  end
            if (u.bus_oe)  n_bus++;
            if (u.bus_oe && u.alu_oe) overlap++;
            if (u.bus_oe && u.bus_data !== 8'(opnd)) bad_bus++;
            if (u.done) begin
                got = 1'b1;
                break;
            end
            @(negedge CLK);
            cyc++;
        end

        if (ld) begin
            r = opnd;
            c = 1'b0;
        end else begin
            ref_alu(op, exp_acc, opnd, r, c);
        end
        exp_acc = r;
        exp_res = r;
        exp_z   = (r == 0);
        exp_c   = c;

        check({tag, " done seen"}, {31'd0, got}, 32'd1);
        check({tag, " latency"}, cyc, lat + halt_len);
        check({tag, " acc_we cnt/pos"}, {n_acc[15:0], p_acc[15:0]}, {16'd1, 16'(lat - 1)});
        check({tag, " breg_we cnt/pos"}, {n_breg[15:0], p_breg[15:0]},
              bin ? {16'd1, 16'd1} : 32'd0);
        check({tag, " alu_oe cnt/pos"}, {n_alu[15:0], p_alu[15:0]},
              ld ? 32'd0 : {16'd2, (bin ? 16'd2 : 16'd1)});
        check({tag, " bus_oe cnt"}, n_bus, (ld || bin) ? 1 : 0);
        check({tag, " oe overlap/bus data"}, {overlap[15:0], bad_bus[15:0]}, 32'd0);
        check({tag, " result"}, {24'd0, u.result}, exp_res);
        check({tag, " acc"}, {24'd0, acc}, exp_acc);
        check({tag, " flags"}, {30'd0, u.flag_z, u.flag_c},
              FLAGS_EN ? {30'd0, exp_z, exp_c} : 32'd0);
    endtask

    task automatic run_cmd(input bit ld, input int op, input int opnd,
                           input int halt_at, input int halt_len, input string tag);
        issue(ld, op, opnd, tag);
        watch(ld, op, opnd, halt_at, halt_len, tag);
    endtask

    initial begin
        int opnd, op, lat, hat, hlen;
        bit ld;
        RESET         = 1'b1;
        HLT           = 1'b0;
        u.cmd_valid   = 1'b0;
        u.cmd_ld      = 1'b0;
        u.cmd_op      = 3'd0;
        u.cmd_operand = 8'd0;
        #2;
        check("reset strobes", {26'd0, u.bus_oe, u.alu_oe, u.breg_we, u.acc_we, u.done, u.busy}, 32'd0);
        check("reset ready", {31'd0, u.cmd_ready}, 32'd1);
        check("reset result/flags", {22'd0, u.result, u.flag_z, u.flag_c}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        run_cmd(1'b1, 0, 8'hAA, 0, 0, "ld_aa");
        run_cmd(1'b0, 0, 8'h55, 0, 0, "add_55");
        run_cmd(1'b1, 0, 8'hAA, 0, 0, "ld_aa2");
        run_cmd(1'b0, 1, 8'h55, 0, 0, "sub_55");
        run_cmd(1'b0, 2, 8'h00, 0, 0, "dec");
        run_cmd(1'b1, 0, 8'hFF, 0, 0, "ld_ff");
        run_cmd(1'b0, 3, 8'h00, 0, 0, "inc_wrap");
        run_cmd(1'b1, 0, 8'hF0, 0, 0, "ld_f0");
        run_cmd(1'b0, 7, 8'h0F, 2, 3, "bxr_halt");
        run_cmd(1'b1, 0, 8'h00, 0, 0, "ld_zero");
        run_cmd(1'b1, 0, 8'h3C, 0, 0, "ld_3c");

        // Reset while BREG is being loaded drops the command; OC then waits for reset release.
        issue(1'b0, 0, 8'h33, "rst_add");
        #1;
        check("rst loadb breg_we", {31'd0, u.breg_we}, 32'd1);
        RESET = 1'b1;
        #1;
        check("rst strobes", {26'd0, u.bus_oe, u.alu_oe, u.breg_we, u.acc_we, u.done, u.busy}, 32'd0);
        check("rst bus/op", {21'd0, u.bus_data, u.alu_op}, 32'd0);
        check("rst result/flags", {22'd0, u.result, u.flag_z, u.flag_c}, 32'd0);
        exp_res = 0;
        opnd = int'($urandom_range(0, 255));
        u.cmd_valid   = 1'b1;
        u.cmd_ld      = 1'b0;
        u.cmd_op      = 3'd4;
        u.cmd_operand = 8'(opnd);
        repeat (2) begin
            @(negedge CLK);
            #1;
            check("rst no done/busy", {30'd0, u.done, u.busy}, 32'd0);
        end
        RESET = 1'b0;
        @(negedge CLK);
        u.cmd_valid = 1'b0;
        watch(1'b0, 4, opnd, 0, 0, "oc_after_rst");

        for (int i = 0; i < 40; i++) begin
            ld   = ($urandom_range(0, 3) == 0);
            op   = int'($urandom_range(0, 7));
            opnd = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            lat  = ld ? 2 : (is_bin(op) ? 4 : 3);
            hlen = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            hat  = int'($urandom_range(1, lat));
            run_cmd(ld, op, opnd, hat, hlen, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
